// File: rtl/dac_ctrl_pkg.sv
// Shared types for the DAC sample scheduler: sample width and FSM state encoding.
package dac_ctrl_pkg;

    localparam int unsigned SAMPLE_W = 16;

    typedef enum logic [1:0] {
        MUTED = 2'd0,
        FILL  = 2'd1,
        PLAY  = 2'd2,
        RAMP  = 2'd3
    } dac_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous DEPTH x WIDTH sample FIFO with occupancy count and synchronous flush.
// Reads are registered-pointer based: a word pushed this cycle is only visible next cycle.
module sample_fifo
    import dac_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = SAMPLE_W
) (
    input  logic                     i_clk,
    input  logic                     i_res,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Paces buffered samples into the sigma-delta DAC once per OSR clocks, prefilling
// before playback and ramping linearly to zero on underrun or disable.
module dac_sample_scheduler
    import dac_ctrl_pkg::*;
#(
    parameter int unsigned OSR         = 256,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned START_LEVEL = 4,
    parameter int unsigned RAMP_STEP   = 4096
) (
    input  logic                        i_clk,
    input  logic                        i_res,
    input  logic                        i_enable,
    input  logic signed [SAMPLE_W-1:0]  i_sample,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic signed [SAMPLE_W-1:0]  o_func,
    output logic                        o_sample_tick,
    output logic                        o_underrun,
    input  logic                        i_clr_underrun,
    output logic [1:0]                  o_state,
    output logic [$clog2(DEPTH):0]      o_level
);

    localparam int unsigned CW = $clog2(OSR);
    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(OSR - 1);
    localparam logic signed [SAMPLE_W:0] STEP_EXT = (SAMPLE_W+1)'(RAMP_STEP);

    dac_state_t                 state;
    dac_state_t                 state_nxt;
    logic [CW-1:0]              cnt;
    logic [CW-1:0]              rcnt;
    logic                       tick;
    logic                       slot;
    logic                       stop;
    logic                       stop_nxt;
    logic                       pop;
    logic                       flush;
    logic                       set_underrun;
    logic                       full;
    logic                       empty;
    logic [SAMPLE_W-1:0]        head;
    logic signed [SAMPLE_W-1:0] func_nxt;
    logic signed [SAMPLE_W:0]   f_ext;
    logic signed [SAMPLE_W:0]   f_stepped;
    logic [SAMPLE_W:0]          f_mag;
    logic                       ramp_done;
    logic signed [SAMPLE_W-1:0] ramp_val;

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
        return (v == LAST) ? '0 : v + 1'b1;
    endfunction

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_res   (i_res),
        .push    (i_valid && o_ready),
        .wr_data (i_sample),
        .pop     (pop),
        .flush   (flush),
        .rd_data (head),
        .level   (o_level),
        .full    (full),
        .empty   (empty)
    );

    assign o_ready = i_enable && !full;
    assign o_state = state;
    assign tick    = (cnt == LAST);
    // While disabled the main counter is parked, so ramp pacing follows the private count,
    // which shadows the main counter whenever it is running.
    assign slot    = i_enable ? tick : ((state == RAMP) && (rcnt == LAST));

    // Ramp arithmetic in 17 bits so that -32768 has a representable magnitude.
    always_comb begin
        f_ext     = {o_func[SAMPLE_W-1], o_func};
        f_mag     = f_ext[SAMPLE_W] ? (SAMPLE_W+1)'(-f_ext) : (SAMPLE_W+1)'(f_ext);
        ramp_done = ({{(31-SAMPLE_W){1'b0}}, f_mag} <= RAMP_STEP);
        f_stepped = f_ext[SAMPLE_W] ? (f_ext + STEP_EXT) : (f_ext - STEP_EXT);
        ramp_val  = ramp_done ? '0 : f_stepped[SAMPLE_W-1:0];
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt    = state;
        func_nxt     = o_func;
        stop_nxt     = stop;
        pop          = 1'b0;
        set_underrun = 1'b0;
        case (state)
            MUTED: begin
                func_nxt = '0;
                stop_nxt = 1'b0;
                if (i_enable) state_nxt = FILL;
            end
            FILL: begin
                if (!i_enable) begin
                    state_nxt = MUTED;
                end else if (tick && (o_level >= LW'(START_LEVEL))) begin
                    state_nxt = PLAY;
                    pop       = 1'b1;
                    func_nxt  = head;
                end
            end
            PLAY: begin
                if (!i_enable) begin
                    state_nxt = RAMP;
                    stop_nxt  = 1'b1;
                end else if (tick) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        func_nxt = head;
                    end else begin
                        set_underrun = 1'b1;
                        state_nxt    = RAMP;
                    end
                end
            end
            RAMP: begin
                if (slot) begin
                    func_nxt = ramp_val;
                    if (ramp_done) begin
                        state_nxt = (stop || !i_enable) ? MUTED : FILL;
                        stop_nxt  = 1'b0;
                    end
                end
            end
            default: state_nxt = MUTED;
        endcase
        flush = (state_nxt == MUTED);
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) state <= MUTED;
        else        state <= state_nxt;
    end

    // Rate counters, output sample, tick strobe, stop flag and sticky underrun.
    always_ff @(posedge i_clk or negedge i_res) begin
        if (!i_res) begin
            cnt           <= '0;
            rcnt          <= '0;
            o_func        <= '0;
            o_sample_tick <= 1'b0;
            stop          <= 1'b0;
            o_underrun    <= 1'b0;
        end else begin
            cnt           <= i_enable ? wrap_inc(cnt) : '0;
            rcnt          <= ((state == RAMP) && !i_enable) ? wrap_inc(rcnt) : wrap_inc(cnt);
            o_func        <= func_nxt;
            o_sample_tick <= slot;
            stop          <= stop_nxt;
            if (set_underrun)        o_underrun <= 1'b1;
            else if (i_clr_underrun) o_underrun <= 1'b0;
        end
    end

endmodule
